// File: rtl/wf_issue_arbiter_pkg.sv
// Shared global definitions for the wavefront issue arbiter slice.
// Every file that needs the CU geometry imports it from here so the
// slot count and id width are defined in exactly one place.
package wf_issue_arbiter_pkg;

    // Wavefront slots per compute unit and the width of a wavefront id.
    localparam int GLB_WF_PER_CU    = 40;
    localparam int GLB_WF_ID_LENGTH = 6;

    // Width of the candidate / mask vectors seen by the arbiter.
    typedef logic [GLB_WF_PER_CU-1:0]    wf_vec_t;
    typedef logic [GLB_WF_ID_LENGTH-1:0] wf_id_t;

endpackage : wf_issue_arbiter_pkg

// File: rtl/wf_issue_arbiter_if.sv
// Issue-side bundle between the decode/scoreboard front end and the
// arbiter: per-wavefront readiness, functional unit backpressure, the
// branch flush strobe, and the registered issue result.
interface wf_issue_arbiter_if
    import wf_issue_arbiter_pkg::*;
#(
    parameter int WF_PER_CU    = GLB_WF_PER_CU,
    parameter int WF_ID_LENGTH = GLB_WF_ID_LENGTH
);

    logic [WF_PER_CU-1:0]    valid_entry_in;
    logic [WF_PER_CU-1:0]    wf_ready;
    logic                    fu_ready;
    logic                    flush_en;
    logic [WF_ID_LENGTH-1:0] flush_wfid;
    logic                    issued_valid;
    logic [WF_ID_LENGTH-1:0] issued_wfid;

    // Front end drives requests and observes what was issued.
    modport master (
        output valid_entry_in,
        output wf_ready,
        output fu_ready,
        output flush_en,
        output flush_wfid,
        input  issued_valid,
        input  issued_wfid
    );

    // Arbiter consumes requests and produces the issue result.
    modport slave (
        input  valid_entry_in,
        input  wf_ready,
        input  fu_ready,
        input  flush_en,
        input  flush_wfid,
        output issued_valid,
        output issued_wfid
    );

endinterface : wf_issue_arbiter_if

// File: rtl/wf_issue_arbiter_decoder.sv
// Enabled binary-to-one-hot decoder (6b id to 40b wavefront vector).
// Ids that do not name a real slot decode to all zeros, so an
// out-of-range id can never mask a live wavefront.
module wf_issue_arbiter_decoder
    import wf_issue_arbiter_pkg::*;
#(
    parameter int IN_W  = GLB_WF_ID_LENGTH,
    parameter int OUT_W = GLB_WF_PER_CU
) (
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);

    // One-hot decode, gated by enable and by the id being in range.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        out = '0;
        if (en && (int'(in) < OUT_W)) begin
            out[in] = 1'b1;
        end
    end

endmodule : wf_issue_arbiter_decoder

// File: rtl/wf_issue_arbiter_rr_prio_encoder.sv
// Rotated priority encoder: finds the first set request at or above the
// start pointer, wrapping from the top slot back to slot 0.
// Done as two plain lowest-set searches (upper window, then whole vector)
// rather than a modulo rotation, which keeps the logic shallow.
module rr_prio_encoder
    import wf_issue_arbiter_pkg::*;
#(
    parameter int N     = GLB_WF_PER_CU,
    parameter int IDX_W = GLB_WF_ID_LENGTH
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [N-1:0] hi_req;

    // Requests at or above the pointer take precedence; if none, the
    // lowest request overall wins (the wrapped part of the search).
    always_comb begin
        hi_req = '0;
        for (int i = 0; i < N; i++) begin
            hi_req[i] = req[i] && (i >= int'(start));
        end

        found = |req;
        index = '0;
        // Descending scans: the last hit written is the lowest set bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) index = IDX_W'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (hi_req[i]) index = IDX_W'(i);
        end
    end

endmodule : rr_prio_encoder

// File: rtl/wf_issue_arbiter.sv
// Wavefront issue arbiter: picks at most one ready wavefront per cycle in
// round-robin order and presents it, registered, to the functional unit.
// The wavefront issued last cycle and a wavefront being flushed this
// cycle are excluded from the search.
module wf_issue_arbiter
    import wf_issue_arbiter_pkg::*;
#(
    parameter int WF_PER_CU    = GLB_WF_PER_CU,
    parameter int WF_ID_LENGTH = GLB_WF_ID_LENGTH
) (
    input  logic               clk,
    input  logic               rst,
    wf_issue_arbiter_if.slave  bus
);

    // Architectural state: round-robin pointer and the issue register.
    logic [WF_ID_LENGTH-1:0] rr_ptr;
    logic                    issued_valid_q;
    logic [WF_ID_LENGTH-1:0] issued_wfid_q;

    logic [WF_PER_CU-1:0]    inflight_mask;
    logic [WF_PER_CU-1:0]    flush_mask;
    logic [WF_PER_CU-1:0]    candidates;
    logic                    cand_found;
    logic [WF_ID_LENGTH-1:0] winner;

    // The issued wavefront still shows valid_entry_in for one cycle
    // until decode clears it; mask it so it cannot issue twice in a row.
    wf_issue_arbiter_decoder #(
        .IN_W  (WF_ID_LENGTH),
        .OUT_W (WF_PER_CU)
    ) u_inflight_dec (
        .en  (issued_valid_q),
        .in  (issued_wfid_q),
        .out (inflight_mask)
    );

    // A taken branch kills the flushed wavefront's pending instruction.
    wf_issue_arbiter_decoder #(
        .IN_W  (WF_ID_LENGTH),
        .OUT_W (WF_PER_CU)
    ) u_flush_dec (
        .en  (bus.flush_en),
        .in  (bus.flush_wfid),
        .out (flush_mask)
    );

    assign candidates = bus.valid_entry_in & bus.wf_ready & ~inflight_mask & ~flush_mask;

    rr_prio_encoder #(
        .N     (WF_PER_CU),
        .IDX_W (WF_ID_LENGTH)
    ) u_rr_enc (
        .req   (candidates),
        .start (rr_ptr),
        .found (cand_found),
        .index (winner)
    );

    // Register the winner when the functional unit can accept it and
    // advance the pointer just past it; otherwise hold id and pointer.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: only the three state registers exist, so all of them are reset; nothing pending survives reset.
            issued_valid_q <= 1'b0;
            issued_wfid_q  <= '0;
            rr_ptr         <= '0;
        end else if (bus.fu_ready && cand_found) begin
            issued_valid_q <= 1'b1;
            issued_wfid_q  <= winner;
            rr_ptr         <= (winner == WF_ID_LENGTH'(WF_PER_CU - 1)) ? '0 : winner + 1'b1;
        end else begin
            issued_valid_q <= 1'b0;
        end
    end

    assign bus.issued_valid = issued_valid_q;
    assign bus.issued_wfid  = issued_wfid_q;

endmodule : wf_issue_arbiter

// File: tb/tb_wf_issue_arbiter.sv
// Directed bench for wf_issue_arbiter: each step applies a request
// pattern, advances one clock and compares the registered issue result
// against a hand-derived value.
module tb_wf_issue_arbiter;

    localparam int N = 40;
    localparam int W = 6;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    wf_issue_arbiter_if #(.WF_PER_CU(N), .WF_ID_LENGTH(W)) bus ();

    wf_issue_arbiter #(
        .WF_PER_CU    (N),
        .WF_ID_LENGTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] wf_bit(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land just after the edge, where the
    // registered outputs are settled and new inputs can be applied.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cands(input logic [N-1:0] v);
        bus.valid_entry_in = v;
        bus.wf_ready       = v;
    endtask

    logic [N-1:0] model_valid;
    logic [N-1:0] seen;
    int           pending;

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset dominates fully-ready candidates and fu_ready.
        rst            = 1'b1;
        bus.valid_entry_in = '1;
        bus.wf_ready       = '1;
        bus.fu_ready       = 1'b1;
        bus.flush_en       = 1'b0;
        bus.flush_wfid     = '0;
        tick();
        tick();
        check("reset_valid", 64'(bus.issued_valid), 64'd0);
        check("reset_wfid",  64'(bus.issued_wfid),  64'd0);

        // Candidates {0,5}: 0, then 5, then 0 again (never 0 back to back).
        set_cands(wf_bit(0) | wf_bit(5));
        rst = 1'b0;
        tick();
        check("c05_first_valid", 64'(bus.issued_valid), 64'd1);
        check("c05_first_wfid",  64'(bus.issued_wfid),  64'd0);
        tick();
        check("c05_second_wfid", 64'(bus.issued_wfid),  64'd5);
        tick();
        check("c05_third_wfid",  64'(bus.issued_wfid),  64'd0);
        set_cands('0);
        tick();
        check("idle_valid", 64'(bus.issued_valid), 64'd0);
        check("idle_hold",  64'(bus.issued_wfid),  64'd0);

        // Candidate {7} stalled by fu_ready=0 for three cycles.
        set_cands(wf_bit(7));
        bus.fu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 64'(bus.issued_valid), 64'd0);
            check("stall_hold",  64'(bus.issued_wfid),  64'd0);
        end
        bus.fu_ready = 1'b1;
        tick();
        check("stall_release_valid", 64'(bus.issued_valid), 64'd1);
        check("stall_release_wfid",  64'(bus.issued_wfid),  64'd7);
        set_cands('0);
        tick();
        check("post_stall_hold", 64'(bus.issued_wfid), 64'd7);

        // Issue 38 so the pointer sits at 39, then {3,39}: 39 then wrap to 3.
        set_cands(wf_bit(38));
        tick();
        check("wf38", 64'(bus.issued_wfid), 64'd38);
        set_cands(wf_bit(3) | wf_bit(39));
        tick();
        check("wrap_wf39", 64'(bus.issued_wfid), 64'd39);
        tick();
        check("wrap_wf3",  64'(bus.issued_wfid), 64'd3);
        set_cands('0);
        tick();
        check("wrap_idle", 64'(bus.issued_valid), 64'd0);

        // Issue 9 so the pointer sits at 10; flush of 10 hands the slot to 12.
        set_cands(wf_bit(9));
        tick();
        check("wf9", 64'(bus.issued_wfid), 64'd9);
        set_cands(wf_bit(10) | wf_bit(12));
        bus.flush_en   = 1'b1;
        bus.flush_wfid = W'(10);
        tick();
        check("flush_skip_valid", 64'(bus.issued_valid), 64'd1);
        check("flush_skip_wfid",  64'(bus.issued_wfid),  64'd12);
        // Out-of-range flush id masks nothing: pointer 13 wraps to 10.
        bus.flush_wfid = W'(50);
        tick();
        check("flush_oor_wfid", 64'(bus.issued_wfid), 64'd10);
        bus.flush_en = 1'b0;
        set_cands('0);
        tick();

        // All 40 ready, valid cleared the cycle after issue: 0..39 in order.
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        model_valid = '1;
        bus.wf_ready = '1;
        seen        = '0;
        pending     = -1;
        for (int k = 0; k < N; k++) begin
            bus.valid_entry_in = model_valid;
            tick();
            check("sweep_valid", 64'(bus.issued_valid), 64'd1);
            check("sweep_wfid",  64'(bus.issued_wfid),  64'(k));
            seen = seen | wf_bit(k);
            if (pending >= 0) model_valid[pending] = 1'b0;
            pending = k;
        end
        bus.valid_entry_in = model_valid;
        tick();
        check("sweep_no_repeat", 64'(bus.issued_valid), 64'd0);
        check("sweep_each_once", 64'(seen), 64'({N{1'b1}}));
        set_cands('0);
        tick();

        // Pointer at 20 (after issuing 19); reset drops the pick of 25.
        set_cands(wf_bit(19));
        tick();
        check("wf19", 64'(bus.issued_wfid), 64'd19);
        set_cands(wf_bit(3) | wf_bit(25));
        rst = 1'b1;
        tick();
        check("midrst_valid", 64'(bus.issued_valid), 64'd0);
        check("midrst_wfid",  64'(bus.issued_wfid),  64'd0);
        rst = 1'b0;
        tick();
        check("postrst_valid", 64'(bus.issued_valid), 64'd1);
        check("postrst_wfid",  64'(bus.issued_wfid),  64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_wf_issue_arbiter
